frame_loader: RTL

- Upstream neighbour of Downscale_SIMD. Accepts a row-major 8-bit pixel stream over a valid/ready handshake and assembles a full SRC_H x SRC_W source frame in an internal buffer.
- When the buffer is full, presents the frame as a stable 2-D array and pulses the downscaler's start. It then holds the frame until the downscaler's done, and only after that accepts the next frame.

---
 rtl/frame_loader.sv | 90 +++++++++
 1 files changed

// File: rtl/frame_loader.sv
// frame_loader: assembles a row-major pixel stream into a SRC_H x SRC_W frame and hands it to the downscaler.
// Optional FRAME_LOADER_SOF_RESYNC_EN: a pix_sof beat restarts the frame at buf[0][0].
module frame_loader #(
    parameter int SRC_H = 32,
    parameter int SRC_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_valid,
    input  logic [7:0]       pix_data,
    input  logic             pix_sof,
    output logic             pix_ready,
    output logic [7:0]       image_out [0:SRC_H-1][0:SRC_W-1],
    output logic             start,
    input  logic             done,
    output logic             busy,
    output logic [CNT_W-1:0] frame_count
);
    localparam int RW = SRC_H > 1 ? $clog2(SRC_H) : 1;
    localparam int CW = SRC_W > 1 ? $clog2(SRC_W) : 1;
    localparam logic [RW-1:0] LAST_R = RW'(SRC_H - 1);
    localparam logic [CW-1:0] LAST_C = CW'(SRC_W - 1);

    typedef enum logic [1:0] {LOAD, FIRE, WAIT} state_t;

    state_t      r_state;
    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic [7:0]  r_buf [0:SRC_H-1][0:SRC_W-1];
    logic        w_col_last;
    logic        w_row_last;

    assign w_col_last = r_col == LAST_C;
    assign w_row_last = r_row == LAST_R;
    assign pix_ready  = r_state == LOAD && !rst;
    assign image_out  = r_buf;

`ifndef FRAME_LOADER_SOF_RESYNC_EN
    logic w_unused_sof;
    assign w_unused_sof = pix_sof;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= LOAD;
            r_row       <= '0;
            r_col       <= '0;
            start       <= 1'b0;
            busy        <= 1'b0;
            frame_count <= '0;
            for (int i = 0; i < SRC_H; i++)
                for (int j = 0; j < SRC_W; j++)
                    r_buf[i][j] <= '0;
        end else begin
            case (r_state)
                LOAD: if (pix_valid) begin
`ifdef FRAME_LOADER_SOF_RESYNC_EN
                    // A marked beat always restarts the frame, even on the last position
                    if (pix_sof) begin
                        r_buf[0][0] <= pix_data;
                        r_row       <= '0;
                        r_col       <= CW'(1);
                    end else
`endif
                    begin
                        r_buf[r_row][r_col] <= pix_data;
                        r_col <= w_col_last ? '0 : r_col + 1'b1;
                        r_row <= w_col_last ? (w_row_last ? '0 : r_row + 1'b1) : r_row;
                        if (w_col_last && w_row_last) begin
                            r_state <= FIRE;
                            start   <= 1'b1;
                            busy    <= 1'b1;
                        end
                    end
                end
                FIRE: begin
                    start   <= 1'b0;
                    r_state <= WAIT;
                end
                WAIT: if (done) begin
                    r_state     <= LOAD;
                    busy        <= 1'b0;
                    frame_count <= frame_count + 1'b1;
                end
                default: r_state <= LOAD;
            endcase
        end
    end
endmodule
